fwvip_wb_arbiter: RTL and testbench
===================================

FWVIP_WB_ARBITER -- requirements
Module: fwvip_wb_arbiter

Interface
REQ-001 N_INIT, 4, number of Wishbone initiators sharing one target (2..8).
REQ-002 ADDR_WIDTH, 32, address width.
REQ-003 DATA_WIDTH, 32, data width; SEL width = DATA_WIDTH/8.
REQ-004 TIMEOUT, 256, max stalled cycles per access; 0 disables watchdog.
REQ-005 clock  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 tadr  input  N_INIT*ADDR_WIDTH  per-initiator address, slice k = initiator k.
REQ-008 tdat_w  input  N_INIT*DATA_WIDTH  per-initiator write data.
REQ-009 tdat_r  output  N_INIT*DATA_WIDTH  per-initiator read data.
REQ-010 tcyc  input  N_INIT  per-initiator CYC (request).
REQ-011 tstb  input  N_INIT  per-initiator STB.
REQ-012 tsel  input  N_INIT*DATA_WIDTH/8  per-initiator byte selects.
REQ-013 twe  input  N_INIT  per-initiator write enable.
REQ-014 tack  output  N_INIT  per-initiator ACK.
REQ-015 terr  output  N_INIT  per-initiator ERR.
REQ-016 iadr  output  ADDR_WIDTH  shared target address.
REQ-017 idat_w  output  DATA_WIDTH  shared target write data.
REQ-018 idat_r  input  DATA_WIDTH  shared target read data.
REQ-019 icyc, istb, iwe  output  1 each  shared target CYC/STB/WE.
REQ-020 isel  output  DATA_WIDTH/8  shared target byte selects.
REQ-021 iack, ierr  input  1 each  shared target ACK/ERR.
REQ-022 gnt  output  N_INIT  one-hot current grant; all-zero when no owner.

Function
REQ-023 FSM states: IDLE, BUSY, ABORT.
REQ-024 IDLE: if tcyc != 0, pick winner round-robin starting at index (last+1) mod N_INIT; register gnt, last <= winner, go BUSY; 1-cycle arbitration latency.
REQ-025 IDLE: icyc=istb=0, gnt=0, all tack/terr=0, all tdat_r=0.
REQ-026 BUSY, owner g: icyc=tcyc[g], istb=tstb[g], iadr/idat_w/isel/iwe = slice g, combinational mux, zero added latency.
REQ-027 BUSY: tack[g]=iack, terr[g]=ierr, tdat_r slice g = idat_r, combinational; non-owners get 0 on all three.
REQ-028 BUSY: grant held for whole CYC (multiple STB beats allowed); tcyc[g]=0 -> IDLE next cycle (one dead cycle between owners).
REQ-029 Watchdog counter: clears on entry to BUSY and on any iack|ierr; increments each BUSY cycle with istb=1 and iack=ierr=0; saturates.
REQ-030 Counter reaching TIMEOUT (TIMEOUT>0): terr[g]=1 for exactly one cycle, go ABORT; iack/ierr arriving that same cycle take precedence (no timeout).
REQ-031 ABORT: icyc=istb=0, tack/terr all 0, gnt held; tcyc[g]=0 -> IDLE.
REQ-032 Requests from non-owners never affect owner's signals; simultaneous requests resolved only by round-robin.
REQ-033 tcyc[g] dropping in the same cycle as iack: ack still forwarded that cycle, then IDLE.

Reset
REQ-034 Reset: state=IDLE, gnt=0, counter=0, last=N_INIT-1 (initiator 0 wins first); all outputs 0.
REQ-035 Reset mid-access drops icyc immediately (asynchronous); in-flight transfer discarded, no ack/err forwarded.

Structure
REQ-036 Package fwvip_wb_arb_pkg: FSM state enum, counter width constant derived from TIMEOUT.
REQ-037 Sub-module fwvip_rr_pick: combinational round-robin picker (req vector, last index -> one-hot winner, valid).

Verification
REQ-038 Reset release, tcyc=4'b0001, write adr=0x10 dat=0xA5 -> gnt=0001 next cycle, iadr=0x10, tack[0] mirrors iack.
REQ-039 tcyc=4'b1111 held, each 1-beat access -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-040 Owner 2 runs 3 STB beats, initiator 0 requesting throughout -> gnt stays 0100 until tcyc[2] drops.
REQ-041 TIMEOUT=8, target never acks -> terr[g] pulses once after 8 stalled cycles, icyc=0, IDLE after tcyc[g] drops.
REQ-042 ierr=1 on owner 1 read -> terr[1]=1 same cycle, tack=0, tack/terr of others 0.
REQ-043 Reset asserted mid-BUSY -> icyc=0 and gnt=0 immediately; next grant goes to initiator 0.

Source files
------------

// File: rtl/fwvip_wb_arb_pkg.sv
// Shared types and sizing helpers for the Wishbone N:1 arbiter.
package fwvip_wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 256;

  // Watchdog counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    if (timeout < 1) return 1;
    return $clog2(timeout + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_TIMEOUT);

endpackage

// File: rtl/fwvip_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last winner.
module fwvip_rr_pick
  import fwvip_wb_arb_pkg::*;
#(
  parameter int N_INIT = 4,
  parameter int IDX_W  = $clog2(N_INIT)
) (
  input  logic [N_INIT-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [N_INIT-1:0] winner,
  output logic [IDX_W-1:0]  winner_idx,
  output logic              valid
);

  // Walk the request vector from last+1, wrapping, and take the first requester.
  always_comb begin
    int cand;
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = 0;
    for (int i = 1; i <= N_INIT; i++) begin
      cand = (int'(last) + i) % N_INIT;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fwvip_wb_arbiter.sv
// Wishbone N-initiator to 1-target arbiter with round-robin grant and a
// stall watchdog that terminates hung accesses with an error.
module fwvip_wb_arbiter
  import fwvip_wb_arb_pkg::*;
#(
  parameter int N_INIT     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_INIT*ADDR_WIDTH-1:0]   tadr,
  input  logic [N_INIT*DATA_WIDTH-1:0]   tdat_w,
  output logic [N_INIT*DATA_WIDTH-1:0]   tdat_r,
  input  logic [N_INIT-1:0]              tcyc,
  input  logic [N_INIT-1:0]              tstb,
  input  logic [N_INIT*DATA_WIDTH/8-1:0] tsel,
  input  logic [N_INIT-1:0]              twe,
  output logic [N_INIT-1:0]              tack,
  output logic [N_INIT-1:0]              terr,
  output logic [ADDR_WIDTH-1:0]          iadr,
  output logic [DATA_WIDTH-1:0]          idat_w,
  input  logic [DATA_WIDTH-1:0]          idat_r,
  output logic                           icyc,
  output logic                           istb,
  output logic                           iwe,
  output logic [DATA_WIDTH/8-1:0]        isel,
  input  logic                           iack,
  input  logic                           ierr,
  output logic [N_INIT-1:0]              gnt
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(N_INIT);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_e        state, state_next;
  logic [IDX_W-1:0]  last;
  logic [CNT_W-1:0]  wd_cnt;
  logic [N_INIT-1:0] pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              grant_load;
  logic              own_cyc;
  logic              timeout_hit;
  int                owner;

  // The last winner doubles as the current owner while a grant is held.
  assign owner       = int'(last);
  assign own_cyc     = tcyc[owner];
  assign timeout_hit = (TIMEOUT > 0) && (wd_cnt == TO_CNT) && !iack && !ierr;

  fwvip_rr_pick #(
    .N_INIT (N_INIT),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req        (tcyc),
    .last       (last),
    .winner     (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // Next-state decision plus combinational steering between owner and target.
  always_comb begin
    state_next = state;
    grant_load = 1'b0;
    icyc       = 1'b0;
    istb       = 1'b0;
    iwe        = 1'b0;
    iadr       = '0;
    idat_w     = '0;
    isel       = '0;
    tack       = '0;
    terr       = '0;
    tdat_r     = '0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_load = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        icyc   = own_cyc;
        istb   = tstb[owner];
        iwe    = twe[owner];
        iadr   = tadr[owner*ADDR_WIDTH +: ADDR_WIDTH];
        idat_w = tdat_w[owner*DATA_WIDTH +: DATA_WIDTH];
        isel   = tsel[owner*SEL_W +: SEL_W];
        tack[owner] = iack;
        terr[owner] = ierr;
        tdat_r[owner*DATA_WIDTH +: DATA_WIDTH] = idat_r;
        if (!own_cyc) begin
          state_next = ST_IDLE;
        end else if (timeout_hit) begin
          terr[owner] = 1'b1;
          state_next  = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!own_cyc) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Grant, round-robin pointer and watchdog counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt    <= '0;
      last   <= IDX_W'(N_INIT - 1);
      wd_cnt <= '0;
    end else begin
      if (grant_load) begin
        gnt  <= pick_oh;
        last <= pick_idx;
      end else if (state_next == ST_IDLE) begin
        gnt <= '0;
      end
      if (grant_load || iack || ierr) begin
        wd_cnt <= '0;
      end else if (state == ST_BUSY && istb && wd_cnt != CNT_MAX) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwvip_wb_arbiter.sv
// Directed, table-driven bench for fwvip_wb_arbiter (4 initiators, TIMEOUT=8).
module tb_fwvip_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N*AW-1:0] tadr;
  logic [N*DW-1:0] tdat_w;
  logic [N*DW-1:0] tdat_r;
  logic [N-1:0]    tcyc, tstb, twe, tack, terr, gnt;
  logic [N*SW-1:0] tsel;
  logic [AW-1:0]   iadr;
  logic [DW-1:0]   idat_w;
  logic [DW-1:0]   idat_r;
  logic            icyc, istb, iwe, iack, ierr;
  logic [SW-1:0]   isel;

  logic [AW-1:0] adr_k [N];
  logic [DW-1:0] dat_k [N];
  logic [SW-1:0] sel_k [N];
  localparam logic [DW-1:0] IDR = 32'hC0DE_0001;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string    name;
    logic     rst;
    logic [3:0] cyc, stb, we;
    logic     ack, err;
    logic [3:0] gnt;
    logic     icyc, istb;
    logic [3:0] tack, terr;
    logic     busy;
  } vec_t;

  vec_t tbl[$];

  fwvip_wb_arbiter #(
    .N_INIT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .tadr(tadr), .tdat_w(tdat_w), .tdat_r(tdat_r),
    .tcyc(tcyc), .tstb(tstb), .tsel(tsel), .twe(twe),
    .tack(tack), .terr(terr),
    .iadr(iadr), .idat_w(idat_w), .idat_r(idat_r),
    .icyc(icyc), .istb(istb), .iwe(iwe), .isel(isel),
    .iack(iack), .ierr(ierr), .gnt(gnt)
  );

  always #5 clock = ~clock;

  function automatic vec_t v(string name, logic rst, logic [3:0] cyc, logic [3:0] stb,
                             logic [3:0] we, logic ack, logic err, logic [3:0] g,
                             logic ic, logic is, logic [3:0] ta, logic [3:0] te, logic busy);
    vec_t x;
    x.name = name; x.rst = rst; x.cyc = cyc; x.stb = stb; x.we = we;
    x.ack = ack; x.err = err; x.gnt = g; x.icyc = ic; x.istb = is;
    x.tack = ta; x.terr = te; x.busy = busy;
    return x;
  endfunction

  function automatic int oh2idx(logic [3:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic cmp(string name, string what, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s/%s: got %0h expected %0h", name, what, act, exp);
  endtask

  task automatic applyStimulus(input vec_t x);
    @(negedge clock);
    reset = x.rst;
    tcyc  = x.cyc;
    tstb  = x.stb;
    twe   = x.we;
    iack  = x.ack;
    ierr  = x.err;
    #1;
  endtask

  task automatic checkOutput(input vec_t x);
    int g;
    logic [127:0] exp_tdr;
    exp_tdr = '0;
    cmp(x.name, "gnt",  128'(gnt),  128'(x.gnt));
    cmp(x.name, "icyc", 128'(icyc), 128'(x.icyc));
    cmp(x.name, "istb", 128'(istb), 128'(x.istb));
    cmp(x.name, "tack", 128'(tack), 128'(x.tack));
    cmp(x.name, "terr", 128'(terr), 128'(x.terr));
    if (x.busy) begin
      g = oh2idx(x.gnt);
      cmp(x.name, "iadr",   128'(iadr),   128'(adr_k[g]));
      cmp(x.name, "idat_w", 128'(idat_w), 128'(dat_k[g]));
      cmp(x.name, "isel",   128'(isel),   128'(sel_k[g]));
      cmp(x.name, "iwe",    128'(iwe),    128'(x.we[g]));
      exp_tdr[g*DW +: DW] = IDR;
      cmp(x.name, "tdat_r", 128'(tdat_r), exp_tdr);
    end else if (x.gnt == 4'b0000) begin
      cmp(x.name, "tdat_r", 128'(tdat_r), exp_tdr);
    end
  endtask

  task automatic run(input vec_t x);
    applyStimulus(x);
    checkOutput(x);
  endtask

  initial begin
    vec_t one_hot;
    tcyc = '0; tstb = '0; twe = '0; iack = 1'b0; ierr = 1'b0; idat_r = IDR;
    for (int k = 0; k < N; k++) begin
      adr_k[k] = 32'h10 + 32'h100 * k;
      dat_k[k] = 32'hA5 + 32'h1000 * k;
      sel_k[k] = 4'hF ^ 4'(k);
      tadr[k*AW +: AW]   = adr_k[k];
      tdat_w[k*DW +: DW] = dat_k[k];
      tsel[k*SW +: SW]   = sel_k[k];
    end

    // Reset state and single write from initiator 0.
    tbl.push_back(v("reset",     1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(v("idle",      0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(v("wr0 arb",   0, 4'b0001, 4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(v("wr0 wait",  0, 4'b0001, 4'b0001, 4'b0001, 0, 0, 4'b0001, 1, 1, 4'b0000, 4'b0000, 1));
    tbl.push_back(v("wr0 ack",   0, 4'b0001, 4'b0001, 4'b0001, 1, 0, 4'b0001, 1, 1, 4'b0001, 4'b0000, 1));
    tbl.push_back(v("wr0 drop",  0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 1));
    // Round robin from reset with every initiator requesting.
    tbl.push_back(v("rr reset",  1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(v("rr arb",    0, 4'b1111, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    for (int r = 0; r < 5; r++) begin
      one_hot = v("", 0, 0, 0, 0, 0, 0, 4'b0001 << (r % 4), 0, 0, 0, 0, 0);
      tbl.push_back(v($sformatf("rr%0d ack", r), 0, 4'b1111, 4'b1111, 4'b0000, 1, 0,
                      one_hot.gnt, 1, 1, one_hot.gnt, 4'b0000, 1));
      tbl.push_back(v($sformatf("rr%0d drop", r), 0, ~one_hot.gnt, ~one_hot.gnt, 4'b0000, 0, 0,
                      one_hot.gnt, 0, 0, 4'b0000, 4'b0000, 1));
      if (r < 4)
        tbl.push_back(v($sformatf("rr%0d gap", r), 0, 4'b1111, 4'b1111, 4'b0000, 0, 0,
                        4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    end
    tbl.push_back(v("rr idle",   0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    // Error on owner 1 read, then ack coinciding with CYC drop.
    tbl.push_back(v("err arb",   0, 4'b0011, 4'b0011, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(v("err1",      0, 4'b0011, 4'b0011, 4'b0000, 0, 1, 4'b0010, 1, 1, 4'b0000, 4'b0010, 1));
    tbl.push_back(v("ack+drop",  0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 4'b0010, 0, 0, 4'b0010, 4'b0000, 1));
    tbl.push_back(v("next arb",  0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(v("next ack",  0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 4'b0001, 1, 1, 4'b0001, 4'b0000, 1));
    tbl.push_back(v("next drop", 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 1));
    tbl.push_back(v("next idle", 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));

    foreach (tbl[i]) run(tbl[i]);

    // Owner 2 runs three beats while initiator 0 keeps requesting.
    run(v("burst arb", 0, 4'b0100, 4'b0100, 4'b0100, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    for (int b = 0; b < 3; b++) begin
      run(v("burst wait", 0, 4'b0101, 4'b0101, 4'b0100, 0, 0, 4'b0100, 1, 1, 4'b0000, 4'b0000, 1));
      run(v("burst ack",  0, 4'b0101, 4'b0101, 4'b0100, 1, 0, 4'b0100, 1, 1, 4'b0100, 4'b0000, 1));
      run(v("burst gap",  0, 4'b0101, 4'b0001, 4'b0100, 0, 0, 4'b0100, 1, 0, 4'b0000, 4'b0000, 1));
    end
    run(v("burst drop", 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000, 1));
    run(v("i0 arb",     0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    run(v("i0 ack",     0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 4'b0001, 1, 1, 4'b0001, 4'b0000, 1));
    run(v("i0 drop",    0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 1));
    run(v("i0 idle",    0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));

    // Watchdog: target never answers owner 1.
    run(v("to arb", 0, 4'b0010, 4'b0010, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    for (int k = 1; k <= 8; k++)
      run(v("to stall", 0, 4'b0010, 4'b0010, 4'b0000, 0, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000, 1));
    run(v("to fire",   0, 4'b0010, 4'b0010, 4'b0000, 0, 0, 4'b0010, 1, 1, 4'b0000, 4'b0010, 1));
    run(v("abort1",    0, 4'b0010, 4'b0010, 4'b0000, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 0));
    run(v("abort2",    0, 4'b0010, 4'b0010, 4'b0000, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 0));
    run(v("abort rel", 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 0));
    run(v("to idle",   0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));

    // Ack on the timeout cycle wins over the watchdog.
    run(v("ap arb", 0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    for (int k = 1; k <= 8; k++)
      run(v("ap stall", 0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 1, 4'b0000, 4'b0000, 1));
    run(v("ap ack",   0, 4'b0100, 4'b0100, 4'b0000, 1, 0, 4'b0100, 1, 1, 4'b0100, 4'b0000, 1));
    run(v("ap busy",  0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 1, 4'b0000, 4'b0000, 1));
    run(v("ap drop",  0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000, 1));
    run(v("ap idle",  0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));

    // Reset in the middle of owner 3's access.
    run(v("mr arb",   0, 4'b1000, 4'b1000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    run(v("mr busy",  0, 4'b1000, 4'b1000, 4'b0000, 0, 0, 4'b1000, 1, 1, 4'b0000, 4'b0000, 1));
    run(v("mr reset", 1, 4'b1000, 4'b1000, 4'b0000, 1, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    run(v("mr arb2",  0, 4'b1001, 4'b1001, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));
    run(v("mr i0",    0, 4'b1001, 4'b1001, 4'b0000, 0, 0, 4'b0001, 1, 1, 4'b0000, 4'b0000, 1));
    run(v("mr drop",  0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 1));
    run(v("mr idle",  0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
